red_pitaya_fads_event_fifo: RTL and testbench
=============================================

RED_PITAYA_FADS_EVENT_FIFO -- requirements
Module: red_pitaya_fads_event_fifo

Interface
REQ-001 Parameter AW, default 4, SHALL set the FIFO depth to 2^AW droplet records.
REQ-002 Parameter DWT, default 14, SHALL set the width of the signed intensity field.
REQ-003 adc_clk_i  in  1  SHALL be the single clock; all logic is rising-edge.
REQ-004 adc_rst_i  in  1  SHALL be the reset: synchronous, active-high.
REQ-005 evt_valid_i  in  1  SHALL be a one-cycle pulse marking a completed droplet evaluation from the FADS detector.
REQ-006 evt_width_i  in  32  SHALL carry the droplet width in clock cycles.
REQ-007 evt_intensity_i  in  DWT signed  SHALL carry the droplet peak intensity.
REQ-008 evt_flags_i  in  8  SHALL carry classification flags: bit0 positive, bit1 low_int, bit2 high_int, bit3 short, bit4 long, bit5 sorted, bits7:6 zero.
REQ-009 sys_addr  in  32, sys_wdata  in  32, sys_sel  in  4, sys_wen  in  1, sys_ren  in  1 SHALL form the system bus request.
REQ-010 sys_rdata  out  32, sys_err  out  1, sys_ack  out  1 SHALL form the system bus response.
REQ-011 fifo_nempty_o  out  1 SHALL be high while the FIFO holds at least one record.

Function
REQ-012 A 32-bit timestamp counter SHALL increment every cycle and wrap from 0xFFFFFFFF to 0.
REQ-013 On evt_valid_i with enable=1 and FIFO not full, the block SHALL push {timestamp, evt_width_i, evt_flags_i, evt_intensity_i}; the timestamp is the counter value in the evt_valid_i cycle.
REQ-014 On evt_valid_i with enable=0, the block SHALL discard the event without counting it.
REQ-015 On evt_valid_i with enable=1 and FIFO full with no simultaneous pop, the block SHALL drop the event, set sticky overflow, and increment dropped_cnt, saturating at 0xFFFFFFFF.
REQ-016 Push and pop in the same cycle SHALL both take effect, including when full; count is unchanged and nothing is dropped.
REQ-017 Pop on an empty FIFO SHALL be ignored with no state change and no error.
REQ-018 Pointers SHALL be AW bits and wrap modulo 2^AW; count SHALL be AW+1 bits, range 0..2^AW.
REQ-019 Bus decode SHALL use sys_addr[19:0].
REQ-020 0x00 R status SHALL return {count[15:0], 13'b0, overflow, full, empty}.
REQ-021 0x04, 0x08 and 0x0C R SHALL return head timestamp, head width, and {flags[7:0], 8'b0, sign-extended intensity[15:0]} respectively; they SHALL read 0 when empty.
REQ-022 A write of any data to 0x10 SHALL pop one record.
REQ-023 0x14 R/W control: bit0 enable; bit1 clear, self-clearing and reading 0. Clear SHALL empty the FIFO and zero overflow and dropped_cnt, but not the timestamp; clear SHALL win over a same-cycle push.
REQ-024 0x18 R SHALL return dropped_cnt; 0x1C R SHALL return the live timestamp.
REQ-025 Unmapped addresses SHALL read 0 and ignore writes.
REQ-026 sys_ack SHALL equal (sys_wen|sys_ren) delayed one cycle; sys_rdata SHALL be registered in that cycle; sys_err SHALL always be 0; sys_sel is ignored (full-word access).
REQ-027 Head reads at 0x04-0x0C SHALL not pop; the read data reflects the head in the request cycle.

Reset
REQ-028 While adc_rst_i=1, the block SHALL zero the timestamp, pointers, count, overflow, dropped_cnt, sys_ack, sys_err, sys_rdata and fifo_nempty_o, and set enable=1.
REQ-029 FIFO storage need not be reset; reset asserted mid-operation SHALL discard all records in the next cycle.

Verification
REQ-030 Reset, one event (width 100, intensity 0x0200, flags 0x21) at timestamp 50 -> status count=1; reads of 0x04/0x08/0x0C return 50/100/0x21000200; write 0x10 -> status empty=1.
REQ-031 Push 17 events with AW=4 and no pops -> count=16, full=1, overflow=1, dropped_cnt=1; reading 16 records returns events 1..16 in order.
REQ-032 Full FIFO, evt_valid_i coincident with a pop write -> count stays 16, dropped_cnt unchanged, newest record is at the tail.
REQ-033 Negative intensity -8192 -> 0x0C low half reads 0xE000; pop on empty -> no ack error, count stays 0.
REQ-034 Write 0x14=0 then event -> count 0; write 0x14=3 with 5 records and overflow set -> count=0, overflow=0, dropped_cnt=0, enable=1.
REQ-035 Preload timestamp near wrap: event at 0xFFFFFFFF, next at 0x00000001 -> both stored exactly; adc_rst_i pulse mid-stream -> empty, timestamp 0.

Source files
------------

// File: rtl/red_pitaya_fads_event_fifo.sv
// rtl/red_pitaya_fads_event_fifo.sv - timestamped droplet event FIFO with system-bus readout
module red_pitaya_fads_event_fifo #(
    parameter int AW  = 4,
    parameter int DWT = 14
) (
    input  logic                  adc_clk_i,
    input  logic                  adc_rst_i,
    input  logic                  evt_valid_i,
    input  logic [31:0]           evt_width_i,
    input  logic signed [DWT-1:0] evt_intensity_i,
    input  logic [7:0]            evt_flags_i,
    input  logic [31:0]           sys_addr,
    input  logic [31:0]           sys_wdata,
    input  logic [3:0]            sys_sel,
    input  logic                  sys_wen,
    input  logic                  sys_ren,
    output logic [31:0]           sys_rdata,
    output logic                  sys_err,
    output logic                  sys_ack,
    output logic                  fifo_nempty_o
);

    localparam int DEPTH = 1 << AW;

    // Register map offsets within the 20-bit decode window
    localparam logic [19:0] A_STATUS = 20'h00;
    localparam logic [19:0] A_HEAD_T = 20'h04;
    localparam logic [19:0] A_HEAD_W = 20'h08;
    localparam logic [19:0] A_HEAD_F = 20'h0C;
    localparam logic [19:0] A_POP    = 20'h10;
    localparam logic [19:0] A_CTRL   = 20'h14;
    localparam logic [19:0] A_DROP   = 20'h18;
    localparam logic [19:0] A_TIME   = 20'h1C;

    // Record storage, kept as parallel arrays; never reset
    logic [31:0]           ts_mem    [DEPTH];
    logic [31:0]           width_mem [DEPTH];
    logic [7:0]            flags_mem [DEPTH];
    logic signed [DWT-1:0] int_mem   [DEPTH];

    logic [31:0]   ts_q,      ts_d;
    logic [AW-1:0] wr_ptr_q,  wr_ptr_d;
    logic [AW-1:0] rd_ptr_q,  rd_ptr_d;
    logic [AW:0]   count_q,   count_d;
    logic          ovf_q,     ovf_d;
    logic [31:0]   dropped_q, dropped_d;
    logic          enable_q,  enable_d;
    logic          ack_q,     ack_d;
    logic [31:0]   rdata_q,   rdata_d;

    logic [19:0]   addr;
    logic          empty;
    logic          full;
    logic          wr_pop;
    logic          wr_ctrl;
    logic          clr;
    logic          pop;
    logic          push_req;
    logic          push;
    logic          drop;
    logic [31:0]   rd_mux;
    logic [31:0]   head_ts;
    logic [31:0]   head_width;
    logic [7:0]    head_flags;
    logic signed [15:0] head_int16;
    logic          unused_bits;

    assign addr    = sys_addr[19:0];
    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign wr_pop  = sys_wen && (addr == A_POP);
    assign wr_ctrl = sys_wen && (addr == A_CTRL);
    assign clr     = wr_ctrl && sys_wdata[1];

    // A pop on an empty FIFO is simply ignored; a full FIFO still accepts a push
    // when a pop frees a slot in the same cycle.
    assign pop      = wr_pop && !empty;
    assign push_req = evt_valid_i && enable_q;
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    // Head fields read as zero when nothing is stored
    assign head_ts    = empty ? 32'h0 : ts_mem[rd_ptr_q];
    assign head_width = empty ? 32'h0 : width_mem[rd_ptr_q];
    assign head_flags = empty ? 8'h0  : flags_mem[rd_ptr_q];
    assign head_int16 = empty ? 16'sh0 : 16'(int_mem[rd_ptr_q]);

    assign unused_bits = ^{sys_sel, sys_addr[31:20], sys_wdata[31:2]};

    // Register read multiplexer, evaluated in the request cycle
    always_comb begin
        rd_mux = 32'h0;
        case (addr)
            A_STATUS: rd_mux = {16'(count_q), 13'b0, ovf_q, full, empty};
            A_HEAD_T: rd_mux = head_ts;
            A_HEAD_W: rd_mux = head_width;
            A_HEAD_F: rd_mux = {head_flags, 8'h00, head_int16};
            A_CTRL:   rd_mux = {31'b0, enable_q};
            A_DROP:   rd_mux = dropped_q;
            A_TIME:   rd_mux = ts_q;
            default:  rd_mux = 32'h0;
        endcase
    end

    // Next-state logic; clear overrides any same-cycle push or pop
    always_comb begin
        ts_d      = ts_q + 32'd1;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        dropped_d = dropped_q;
        enable_d  = enable_q;
        ack_d     = sys_wen || sys_ren;
        rdata_d   = sys_ren ? rd_mux : 32'h0;

        if (wr_ctrl) begin
            enable_d = sys_wdata[0];
        end

        if (clr) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            ovf_d     = 1'b0;
            dropped_d = 32'h0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
            if (drop) begin
                ovf_d = 1'b1;
                if (dropped_q != 32'hFFFF_FFFF) begin
                    dropped_d = dropped_q + 32'd1;
                end
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i) begin
            ts_q      <= 32'h0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            dropped_q <= 32'h0;
            enable_q  <= 1'b1;
            ack_q     <= 1'b0;
            rdata_q   <= 32'h0;
        end else begin
            ts_q      <= ts_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            dropped_q <= dropped_d;
            enable_q  <= enable_d;
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
        end
    end

    // Record write port; the timestamp is the counter value in the event cycle
    always_ff @(posedge adc_clk_i) begin
        if (push && !adc_rst_i) begin
            ts_mem[wr_ptr_q]    <= ts_q;
            width_mem[wr_ptr_q] <= evt_width_i;
            flags_mem[wr_ptr_q] <= evt_flags_i;
            int_mem[wr_ptr_q]   <= evt_intensity_i;
        end
    end

    assign sys_rdata     = rdata_q;
    assign sys_ack       = ack_q;
    assign sys_err       = 1'b0;
    assign fifo_nempty_o = !empty;

endmodule

// File: tb/tb_red_pitaya_fads_event_fifo.sv
// tb/tb_red_pitaya_fads_event_fifo.sv - directed self-checking bench for the event FIFO
module tb_red_pitaya_fads_event_fifo;

    logic               clk = 1'b0;
    logic               rst;
    logic               evt_valid;
    logic [31:0]        evt_width;
    logic signed [13:0] evt_int;
    logic [7:0]         evt_flags;
    logic [31:0]        sys_addr;
    logic [31:0]        sys_wdata;
    logic [3:0]         sys_sel;
    logic               sys_wen;
    logic               sys_ren;
    logic [31:0]        sys_rdata;
    logic               sys_err;
    logic               sys_ack;
    logic               nempty;

    int checks   = 0;
    int failures = 0;

    red_pitaya_fads_event_fifo #(.AW(4), .DWT(14)) dut (
        .adc_clk_i       (clk),
        .adc_rst_i       (rst),
        .evt_valid_i     (evt_valid),
        .evt_width_i     (evt_width),
        .evt_intensity_i (evt_int),
        .evt_flags_i     (evt_flags),
        .sys_addr        (sys_addr),
        .sys_wdata       (sys_wdata),
        .sys_sel         (sys_sel),
        .sys_wen         (sys_wen),
        .sys_ren         (sys_ren),
        .sys_rdata       (sys_rdata),
        .sys_err         (sys_err),
        .sys_ack         (sys_ack),
        .fifo_nempty_o   (nempty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [19:0] a, output logic [31:0] d);
        @(negedge clk);
        sys_addr = {12'h0, a};
        sys_ren  = 1'b1;
        @(posedge clk);
        #1;
        d       = sys_rdata;
        sys_ren = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [19:0] a, input logic [31:0] exp);
        logic [31:0] d;
        rd(a, d);
        check(tag, d, exp);
    endtask

    task automatic wr(input logic [19:0] a, input logic [31:0] d);
        @(negedge clk);
        sys_addr  = {12'h0, a};
        sys_wdata = d;
        sys_wen   = 1'b1;
        @(posedge clk);
        #1;
        sys_wen = 1'b0;
    endtask

    task automatic evt(input logic [31:0] w, input logic signed [13:0] i, input logic [7:0] f);
        @(negedge clk);
        evt_width = w;
        evt_int   = i;
        evt_flags = f;
        evt_valid = 1'b1;
        @(posedge clk);
        #1;
        evt_valid = 1'b0;
    endtask

    task automatic evt_wr(input logic [31:0] w, input logic [19:0] a, input logic [31:0] d);
        @(negedge clk);
        evt_width = w;
        evt_int   = 14'sd5;
        evt_flags = 8'h02;
        evt_valid = 1'b1;
        sys_addr  = {12'h0, a};
        sys_wdata = d;
        sys_wen   = 1'b1;
        @(posedge clk);
        #1;
        evt_valid = 1'b0;
        sys_wen   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; evt_valid = 1'b0; evt_width = '0; evt_int = '0; evt_flags = '0;
        sys_addr = '0; sys_wdata = '0; sys_sel = 4'hF; sys_wen = 1'b0; sys_ren = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", {31'b0, sys_ack}, 32'h0);
        check("rst_rdata", sys_rdata, 32'h0);
        check("rst_nempty", {31'b0, nempty}, 32'h0);

        // Single event at timestamp 50
        @(negedge clk);
        rst = 1'b0;
        repeat (50) @(posedge clk);
        evt(32'd100, 14'sh0200, 8'h21);
        check("one_nempty", {31'b0, nempty}, 32'h1);
        rd_chk("one_status", 20'h00, 32'h0001_0000);
        check("one_ack", {31'b0, sys_ack}, 32'h1);
        rd_chk("one_ts", 20'h04, 32'd50);
        rd_chk("one_width", 20'h08, 32'd100);
        rd_chk("one_flags", 20'h0C, 32'h2100_0200);
        wr(20'h10, 32'h0);
        rd_chk("one_empty", 20'h00, 32'h0000_0001);

        // Seventeen events into a sixteen-deep FIFO
        for (int i = 1; i <= 17; i++) begin
            evt(32'(i), 14'(i * 3), 8'(i));
        end
        rd_chk("full_status", 20'h00, 32'h0010_0006);
        rd_chk("full_dropped", 20'h18, 32'd1);
        rd_chk("full_head_w", 20'h08, 32'd1);
        rd_chk("full_head_f", 20'h0C, 32'h0100_0003);

        // Push coincident with pop while full
        evt_wr(32'd1000, 20'h10, 32'h0);
        rd_chk("simul_status", 20'h00, 32'h0010_0006);
        rd_chk("simul_dropped", 20'h18, 32'd1);
        for (int k = 2; k <= 16; k++) begin
            rd_chk("drain_width", 20'h08, 32'(k));
            wr(20'h10, 32'h0);
        end
        rd_chk("tail_width", 20'h08, 32'd1000);
        wr(20'h10, 32'h0);
        rd_chk("drain_status", 20'h00, 32'h0000_0005);

        // Negative intensity sign extension, then pop on empty
        evt(32'd7, -14'sd8192, 8'h01);
        rd_chk("neg_flags", 20'h0C, 32'h0100_E000);
        wr(20'h10, 32'h0);
        rd_chk("empty_head_t", 20'h04, 32'h0);
        wr(20'h10, 32'h0);
        check("epop_ack", {31'b0, sys_ack}, 32'h1);
        check("epop_err", {31'b0, sys_err}, 32'h0);
        rd_chk("epop_status", 20'h00, 32'h0000_0005);

        // Disable, then clear with records and overflow present
        wr(20'h14, 32'h0);
        evt(32'd9, 14'sd1, 8'h01);
        rd_chk("dis_status", 20'h00, 32'h0000_0005);
        rd_chk("dis_ctrl", 20'h14, 32'h0);
        wr(20'h14, 32'h1);
        for (int i = 0; i < 5; i++) begin
            evt(32'(i), 14'sd2, 8'h04);
        end
        rd_chk("five_status", 20'h00, 32'h0005_0004);
        evt_wr(32'd55, 20'h14, 32'h3);
        rd_chk("clr_status", 20'h00, 32'h0000_0001);
        rd_chk("clr_dropped", 20'h18, 32'h0);
        rd_chk("clr_ctrl", 20'h14, 32'h1);
        wr(20'h20, 32'hFFFF_FFFF);
        rd_chk("unmapped", 20'h20, 32'h0);

        // Timestamp wrap
        @(negedge clk);
        force dut.ts_q = 32'hFFFF_FFFF;
        #1;
        release dut.ts_q;
        evt_width = 32'd11; evt_int = 14'sd3; evt_flags = 8'h01;
        evt_valid = 1'b1;
        @(posedge clk);
        #1;
        evt_valid = 1'b0;
        @(posedge clk);
        evt(32'd12, 14'sd4, 8'h01);
        rd_chk("wrap_ts0", 20'h04, 32'hFFFF_FFFF);
        wr(20'h10, 32'h0);
        rd_chk("wrap_ts1", 20'h04, 32'h0000_0001);

        // Reset pulse mid-stream
        evt(32'd13, 14'sd5, 8'h01);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mrst_nempty", {31'b0, nempty}, 32'h0);
        check("mrst_ack", {31'b0, sys_ack}, 32'h0);
        @(negedge clk);
        rst      = 1'b0;
        sys_addr = 32'h1C;
        sys_ren  = 1'b1;
        @(posedge clk);
        #1;
        sys_ren = 1'b0;
        check("mrst_time", sys_rdata, 32'h0);
        rd_chk("mrst_status", 20'h00, 32'h0000_0001);
        rd_chk("mrst_ctrl", 20'h14, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
